// File: rtl/rb_burst_pkg.sv
// Shared types and defaults for the register-bank burst sequencer.
package rb_burst_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // A zero length field means the full 2**len_w beats.
    function automatic int len_to_beats(input int len, input int len_w);
        return (len == 0) ? (1 << len_w) : len;
    endfunction

endpackage

// File: rtl/rb_burst_sequencer_if.sv
// Bank read port (req/ack) and burst output port (valid/ready) of the sequencer.
// master = sequencer side, slave = bank + burst sink side.
interface rb_burst_sequencer_if
    import rb_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              sq_rb_req;
    logic [ADDR_W-1:0] sq_rb_addr;
    logic              rb_sq_ack;
    logic [DATA_W-1:0] rb_sq_data;
    logic              burst_valid;
    logic [DATA_W-1:0] burst_data;
    logic              burst_first;
    logic              burst_last;
    logic              burst_ready;

    modport master (
        output sq_rb_req, sq_rb_addr,
        input  rb_sq_ack, rb_sq_data,
        output burst_valid, burst_data, burst_first, burst_last,
        input  burst_ready
    );

    modport slave (
        input  sq_rb_req, sq_rb_addr,
        output rb_sq_ack, rb_sq_data,
        input  burst_valid, burst_data, burst_first, burst_last,
        output burst_ready
    );
endinterface

// File: rtl/rb_burst_skid.sv
// Two-entry valid/ready buffer with flush; head entry drives the output.
module rb_burst_skid
    import rb_burst_pkg::*;
#(
    parameter int W = DATA_W_DEF + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;

    // Storage and pointers; flush empties the buffer and clears its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (flush_i) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) rd_q <= ~rd_q;
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_q];
    assign count_o     = cnt_q;
endmodule

// File: rtl/rb_burst_sequencer.sv
// Burst read-out sequencer: fetches LEN bytes from the register bank starting at
// BASE and streams them as first/last-marked beats, then pulses done.
// Build option: RB_BURST_PREFETCH_EN overlaps the next bank fetch with the
// current beat through a 2-entry skid buffer (1 beat/cycle).
module rb_burst_sequencer
    import rb_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic [ADDR_W-1:0]    base_i,
    input  logic                 abort_i,
    rb_burst_sequencer_if.master bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 start_err_o
);
    localparam int CNT_W = LEN_W + 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  rem_q;
    logic              first_q;
    logic              req_q;
    logic              done_q;
    logic              err_q;
    logic              start_ok;
    logic              abort_ok;
    logic [CNT_W-1:0]  beats;

    // Abort beats start; abort while idle is a no-op.
    assign start_ok = start_i && !abort_i && (state_q == IDLE);
    assign abort_ok = abort_i && (state_q != IDLE);
    assign beats    = CNT_W'(len_to_beats(32'(len_i), LEN_W));

    assign bus.sq_rb_req  = req_q;
    assign bus.sq_rb_addr = addr_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign start_err_o    = err_q;

`ifdef RB_BURST_PREFETCH_EN
    localparam int PAY_W = DATA_W + 2;

    logic             push;
    logic             pop;
    logic             sk_valid;
    logic [PAY_W-1:0] sk_data;
    logic [1:0]       sk_count;
    logic [2:0]       cnt_nx;
    logic             more;

    // rem_q counts beats still to fetch; first_q marks the next fetch as beat 0.
    assign push   = req_q && bus.rb_sq_ack && (state_q == FETCH);
    assign pop    = sk_valid && bus.burst_ready;
    assign cnt_nx = 3'(sk_count) + 3'(push) - 3'(pop);
    assign more   = push ? (rem_q != CNT_W'(1)) : (rem_q != '0);

    rb_burst_skid #(.W(PAY_W)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (abort_ok),
        .push_i      (push),
        .push_data_i ({first_q, (rem_q == CNT_W'(1)), bus.rb_sq_data}),
        .pop_i       (pop),
        .out_valid_o (sk_valid),
        .out_data_o  (sk_data),
        .count_o     (sk_count)
    );

    assign bus.burst_valid = sk_valid;
    assign bus.burst_data  = sk_data[DATA_W-1:0];
    assign bus.burst_last  = sk_valid && sk_data[DATA_W];
    assign bus.burst_first = sk_valid && sk_data[DATA_W+1];

    // FETCH keeps requesting while a slot is guaranteed free; SEND drains the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= start_i && !abort_i && (state_q != IDLE);
            if (abort_ok) begin
                state_q <= IDLE;
                addr_q  <= '0;
                rem_q   <= '0;
                first_q <= 1'b0;
                req_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_ok) begin
                        addr_q  <= base_i;
                        rem_q   <= beats;
                        first_q <= 1'b1;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                    FETCH: begin
                        if (push) begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            rem_q   <= rem_q - CNT_W'(1);
                            first_q <= 1'b0;
                        end
                        req_q <= (req_q && !bus.rb_sq_ack) || (more && (cnt_nx <= 3'd1));
                        if (push && (rem_q == CNT_W'(1))) state_q <= SEND;
                    end
                    SEND: if (pop && sk_data[DATA_W]) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
`else
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              bfirst_q;
    logic              blast_q;

    assign bus.burst_valid = valid_q;
    assign bus.burst_data  = data_q;
    assign bus.burst_first = bfirst_q;
    assign bus.burst_last  = blast_q;

    // One fetch then one beat per byte; rem_q counts beats not yet accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            first_q  <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            bfirst_q <= 1'b0;
            blast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= start_i && !abort_i && (state_q != IDLE);
            if (abort_ok) begin
                state_q  <= IDLE;
                addr_q   <= '0;
                rem_q    <= '0;
                first_q  <= 1'b0;
                req_q    <= 1'b0;
                valid_q  <= 1'b0;
                data_q   <= '0;
                bfirst_q <= 1'b0;
                blast_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_ok) begin
                        addr_q  <= base_i;
                        rem_q   <= beats;
                        first_q <= 1'b1;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                    FETCH: if (bus.rb_sq_ack) begin
                        req_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        data_q   <= bus.rb_sq_data;
                        bfirst_q <= first_q;
                        blast_q  <= (rem_q == CNT_W'(1));
                        state_q  <= SEND;
                    end
                    SEND: if (bus.burst_ready) begin
                        valid_q  <= 1'b0;
                        bfirst_q <= 1'b0;
                        blast_q  <= 1'b0;
                        first_q  <= 1'b0;
                        addr_q   <= addr_q + ADDR_W'(1);
                        rem_q    <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
`endif

endmodule
